// File: rtl/delay_sequencer_if.sv
// Request/counter handshake bundle between the game FSM, the delay counter and delay_sequencer.
interface delay_sequencer_if #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned PW    = 3
);
    logic             i_Start;
    logic [PW-1:0]    i_Periods;
    logic             i_Abort;
    logic [WIDTH-1:0] i_Count;
    logic             i_TwoSec;
    logic             i_RstOK;
    logic             o_ActCounter;
    logic             o_RstCounter;
    logic             o_Busy;
    logic             o_Done;
    logic             o_Err;
    logic [PW-1:0]    o_Remaining;

    modport master (
        output i_Start, i_Periods, i_Abort, i_Count, i_TwoSec, i_RstOK,
        input  o_ActCounter, o_RstCounter, o_Busy, o_Done, o_Err, o_Remaining
    );

    modport slave (
        input  i_Start, i_Periods, i_Abort, i_Count, i_TwoSec, i_RstOK,
        output o_ActCounter, o_RstCounter, o_Busy, o_Done, o_Err, o_Remaining
    );
endinterface

// File: rtl/delay_sequencer.sv
// Sequences N two-second periods on the 2 kHz delay counter: clear, wait for ack, run, repeat.
module delay_sequencer #(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned PW          = 3,
    parameter int unsigned RST_TIMEOUT = 8
) (
    input  logic           clk_2K,
    input  logic           i_ResetN,
    delay_sequencer_if.slave bus
);

    localparam int unsigned TW = $clog2(RST_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE,
        S_ERROR
    } state_t;

    state_t        state, next_state;
    logic [PW-1:0] remaining, next_remaining;
    logic [TW-1:0] tmo, next_tmo;

    logic act_q, rst_q, busy_q, done_q, err_q;
    logic act_c, rst_c, busy_c, done_c, err_c;
    logic clear_ack_c;

    // A stale-high ack alone is not trusted; the count must also read zero.
    assign clear_ack_c = bus.i_RstOK && (bus.i_Count == WIDTH'(0));

    // Next-state, counters and next-cycle output decode.
    always_comb begin
        next_state     = state;
        next_remaining = remaining;
        next_tmo       = tmo;

        case (state)
            S_IDLE: begin
                if (bus.i_Start) begin
                    if (bus.i_Periods != PW'(0)) begin
                        next_remaining = bus.i_Periods;
                        next_tmo       = TW'(0);
                        next_state     = S_CLEAR;
                    end else begin
                        next_state = S_DONE;
                    end
                end
            end
            S_CLEAR: begin
                if (bus.i_Abort) begin
                    next_state     = S_IDLE;
                    next_remaining = PW'(0);
                    next_tmo       = TW'(0);
                end else if (clear_ack_c) begin
                    next_state = S_RUN;
                end else if (tmo == TW'(RST_TIMEOUT - 1)) begin
                    next_state     = S_ERROR;
                    next_remaining = PW'(0);
                    next_tmo       = TW'(0);
                end else begin
                    next_tmo = tmo + TW'(1);
                end
            end
            S_RUN: begin
                if (bus.i_Abort) begin
                    next_state     = S_IDLE;
                    next_remaining = PW'(0);
                    next_tmo       = TW'(0);
                end else if (bus.i_TwoSec) begin
                    if (remaining > PW'(1)) begin
                        next_remaining = remaining - PW'(1);
                        next_tmo       = TW'(0);
                        next_state     = S_CLEAR;
                    end else begin
                        next_remaining = PW'(0);
                        next_state     = S_DONE;
                    end
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            S_ERROR: begin
                if (bus.i_Abort) begin
                    next_state     = S_IDLE;
                    next_remaining = PW'(0);
                    next_tmo       = TW'(0);
                end
            end
            default: begin
                next_state     = S_IDLE;
                next_remaining = PW'(0);
                next_tmo       = TW'(0);
            end
        endcase

        act_c  = (next_state == S_RUN);
        rst_c  = (next_state == S_CLEAR);
        busy_c = (next_state == S_RUN) || (next_state == S_CLEAR);
        done_c = (next_state == S_DONE);
        err_c  = (next_state == S_ERROR);
    end

    // Outputs are registered alongside the state so they track the registered state exactly.
    always_ff @(posedge clk_2K) begin
        if (!i_ResetN) begin
            state     <= S_IDLE;
            remaining <= PW'(0);
            tmo       <= TW'(0);
            act_q     <= 1'b0;
            rst_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= next_state;
            remaining <= next_remaining;
            tmo       <= next_tmo;
            act_q     <= act_c;
            rst_q     <= rst_c;
            busy_q    <= busy_c;
            done_q    <= done_c;
            err_q     <= err_c;
        end
    end

    assign bus.o_ActCounter = act_q;
    assign bus.o_RstCounter = rst_q;
    assign bus.o_Busy       = busy_q;
    assign bus.o_Done       = done_q;
    assign bus.o_Err        = err_q;
    assign bus.o_Remaining  = remaining;

endmodule

// File: tb/tb_delay_sequencer.sv
// Bench for delay_sequencer: per-cycle vector table plus full-length runs against a 2 kHz counter model.
module tb_delay_sequencer;

    localparam int unsigned WIDTH = 12;
    localparam int unsigned PW    = 3;
    localparam int unsigned TMO   = 8;

    logic clk;
    logic rst_n;

    logic             tb_start, tb_abort, tb_twosec, tb_rstok;
    logic [PW-1:0]    tb_periods;
    logic [WIDTH-1:0] tb_count;

    logic             model_en;
    logic [WIDTH-1:0] mdl_cnt;
    logic             mdl_ok;
    logic             mdl_two;

    int n_vec;
    int n_err;

    delay_sequencer_if #(.WIDTH(WIDTH), .PW(PW)) bus ();

    delay_sequencer #(.WIDTH(WIDTH), .PW(PW), .RST_TIMEOUT(TMO)) dut (
        .clk_2K  (clk),
        .i_ResetN(rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: clears one edge after seeing the clear request, saturates at 4095.
    always @(posedge clk) begin
        if (!model_en) begin
            mdl_cnt <= 12'd1234;
            mdl_ok  <= 1'b0;
        end else if (bus.o_RstCounter) begin
            mdl_cnt <= 12'd0;
            mdl_ok  <= 1'b1;
        end else if (bus.o_ActCounter && mdl_cnt != 12'd4095) begin
            mdl_cnt <= mdl_cnt + 12'd1;
        end
    end
    assign mdl_two = (mdl_cnt == 12'd4095);

    assign bus.i_Start   = tb_start;
    assign bus.i_Periods = tb_periods;
    assign bus.i_Abort   = tb_abort;
    assign bus.i_Count   = model_en ? mdl_cnt : tb_count;
    assign bus.i_TwoSec  = model_en ? mdl_two : tb_twosec;
    assign bus.i_RstOK   = model_en ? mdl_ok  : tb_rstok;

    typedef struct {
        logic          rst_n;
        logic          start;
        logic [PW-1:0] periods;
        logic          abort;
        logic [11:0]   count;
        logic          twosec;
        logic          rstok;
        logic [7:0]    exp;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb_q[$];

    // Expected output word: {act, rst, busy, done, err, remaining[2:0]}
    function automatic logic [7:0] o_idle();
        return 8'b00000_000;
    endfunction
    function automatic logic [7:0] o_clear(input logic [2:0] r);
        return {5'b01100, r};
    endfunction
    function automatic logic [7:0] o_run(input logic [2:0] r);
        return {5'b10100, r};
    endfunction
    function automatic logic [7:0] o_done();
        return 8'b00010_000;
    endfunction
    function automatic logic [7:0] o_err();
        return 8'b00001_000;
    endfunction

    function automatic logic [7:0] dut_word();
        return {bus.o_ActCounter, bus.o_RstCounter, bus.o_Busy, bus.o_Done, bus.o_Err, bus.o_Remaining};
    endfunction

    task automatic add(input logic r, input logic s, input logic [2:0] p, input logic a,
                       input logic [11:0] c, input logic t, input logic k, input logic [7:0] e);
        vec_t v;
        v.rst_n = r; v.start = s; v.periods = p; v.abort = a;
        v.count = c; v.twosec = t; v.rstok = k; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, want, want);
        end
    endtask

    // Drive one full request through the counter model and track the resulting waveform.
    task automatic run_seq(input int p);
        int  rem_q[$];
        int  last_rem, rst_run, act_run, clears, dones, bound;
        bit  fin, done_prev;
        model_en = 1'b1;
        @(negedge clk);
        tb_start   = 1'b1;
        tb_periods = PW'(p);
        for (int k = p; k >= 0; k--) rem_q.push_back(k);
        last_rem = 0; rst_run = 0; act_run = 0; clears = 0; dones = 0;
        fin = 1'b0; done_prev = 1'b0;
        bound = p * 4200 + 40;
        for (int cyc = 0; cyc < bound && !fin; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc == 0) tb_start = 1'b0;
            if (bus.o_ActCounter && bus.o_RstCounter) check("act_rst_overlap", 1, 0);
            if (bus.o_RstCounter) rst_run++;
            else if (rst_run != 0) begin
                check("clear_len", rst_run, 2);
                clears++;
                rst_run = 0;
            end
            if (bus.o_ActCounter) act_run++;
            else if (act_run != 0) begin
                check("run_len", act_run, 4096);
                act_run = 0;
            end
            if (int'(bus.o_Remaining) != last_rem) begin
                if (rem_q.size() == 0) check("remaining_extra_step", int'(bus.o_Remaining), last_rem);
                else check("remaining_step", int'(bus.o_Remaining), rem_q.pop_front());
                last_rem = int'(bus.o_Remaining);
            end
            if (done_prev) begin
                check("post_done_idle", int'(dut_word()), int'(o_idle()));
                fin = 1'b1;
            end
            if (bus.o_Done) begin
                dones++;
                done_prev = 1'b1;
            end
        end
        check("seq_finished", int'(fin), 1);
        check("done_pulses", dones, 1);
        check("clear_phases", clears, p);
        check("remaining_left", rem_q.size(), 0);
        model_en = 1'b0;
    endtask

    initial begin
        vec_t       v;
        logic [7:0] e;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; model_en = 1'b0;
        tb_start = 1'b0; tb_periods = '0; tb_abort = 1'b0;
        tb_count = '0; tb_twosec = 1'b0; tb_rstok = 1'b0;

        // reset, then zero-period request
        add(0, 0, 0, 0, 12'd0,  0, 0, o_idle());
        add(0, 0, 0, 0, 12'd0,  0, 0, o_idle());
        add(1, 0, 0, 0, 12'd0,  0, 0, o_idle());
        add(1, 1, 0, 0, 12'd0,  0, 0, o_done());
        add(1, 0, 0, 0, 12'd0,  0, 0, o_idle());
        // stale ack with non-zero count: eight CLEAR cycles then ERROR
        add(1, 1, 2, 0, 12'd57, 0, 1, o_clear(3'd2));
        for (int i = 0; i < 7; i++) add(1, 0, 0, 0, 12'd57, 0, 1, o_clear(3'd2));
        add(1, 0, 0, 0, 12'd57, 0, 1, o_err());
        add(1, 1, 4, 0, 12'd57, 0, 1, o_err());
        add(1, 0, 0, 1, 12'd57, 0, 1, o_idle());
        // abort beats two-second flag on the last period
        add(1, 1, 1, 0, 12'd57, 0, 0, o_clear(3'd1));
        add(1, 0, 0, 0, 12'd57, 0, 1, o_clear(3'd1));
        add(1, 0, 0, 0, 12'd0,  0, 1, o_run(3'd1));
        add(1, 0, 0, 0, 12'd5,  0, 1, o_run(3'd1));
        add(1, 0, 0, 1, 12'd5,  1, 1, o_idle());
        add(1, 0, 0, 0, 12'd0,  0, 0, o_idle());
        // start during DONE is dropped, not queued
        add(1, 1, 1, 0, 12'd100, 0, 1, o_clear(3'd1));
        add(1, 0, 0, 0, 12'd0,  0, 1, o_run(3'd1));
        add(1, 0, 0, 0, 12'd4095, 1, 1, o_done());
        add(1, 1, 3, 0, 12'd0,  0, 1, o_idle());
        add(1, 0, 0, 0, 12'd0,  0, 1, o_idle());
        // abort beats clear ack
        add(1, 1, 2, 0, 12'd9,  0, 0, o_clear(3'd2));
        add(1, 0, 0, 1, 12'd0,  0, 1, o_idle());
        // reset mid-run wins over start and two-second flag
        add(1, 1, 7, 0, 12'd3,  0, 0, o_clear(3'd7));
        add(1, 0, 0, 0, 12'd0,  0, 1, o_run(3'd7));
        add(1, 0, 0, 0, 12'd4095, 1, 1, o_clear(3'd6));
        add(1, 0, 0, 0, 12'd0,  0, 1, o_run(3'd6));
        add(0, 1, 5, 0, 12'd4095, 1, 1, o_idle());
        add(1, 0, 0, 0, 12'd0,  0, 0, o_idle());

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            @(negedge clk);
            rst_n      = v.rst_n;
            tb_start   = v.start;
            tb_periods = v.periods;
            tb_abort   = v.abort;
            tb_count   = v.count;
            tb_twosec  = v.twosec;
            tb_rstok   = v.rstok;
            sb_q.push_back(v.exp);
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            check($sformatf("vec%0d", i), int'(dut_word()), int'(e));
        end

        @(negedge clk);
        rst_n = 1'b1; tb_start = 1'b0; tb_abort = 1'b0; tb_twosec = 1'b0; tb_rstok = 1'b0;
        run_seq(1);
        run_seq(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/delay_sequencer.md
Name: delay_sequencer

Overview:
- Initiator side of the 2 kHz delay-counter interface.
- Accepts a delay request of N two-second periods from the game FSM.
- Per period: drives the counter's clear and activate controls, waits for the clear acknowledge, then waits for the two-second flag.
- Pulses done when all periods have elapsed; flags an error if the counter never acknowledges a clear.

Parameters:
WIDTH, 12, width of the counter value input i_Count
PW, 3, width of period-count request and remaining-period output
RST_TIMEOUT, 8, max cycles spent in CLEAR before error (>=3)

Ports:
clk_2K  input  1  2 kHz system clock
i_ResetN  input  1  synchronous active-low reset
i_Start  input  1  request; sampled only in IDLE
i_Periods  input  PW  number of 2 s periods requested, latched with i_Start
i_Abort  input  1  cancel current request or clear error
i_Count  input  WIDTH  counter value
i_TwoSec  input  1  counter two-second flag
i_RstOK  input  1  counter clear acknowledge (may remain high after first clear)
o_ActCounter  output  1  enable counting
o_RstCounter  output  1  request counter clear
o_Busy  output  1  request in progress (CLEAR or RUN)
o_Done  output  1  one-cycle completion pulse
o_Err  output  1  clear-handshake timeout, held
o_Remaining  output  PW  periods still to run

Behaviour:
- One clock clk_2K; all state changes on its rising edge; reset synchronous, active-low.
- i_ResetN=0 at an edge: state=IDLE, remaining=0, timeout counter=0, all outputs 0 next cycle.
- Outputs are Moore decodes of registered state: they change the cycle after the transition.
- States: IDLE, CLEAR, RUN, DONE, ERROR.
- IDLE: all outputs 0.
  - i_Start=1 and i_Periods!=0: remaining<=i_Periods, tmo<=0, go to CLEAR.
  - i_Start=1 and i_Periods==0: go directly to DONE.
- CLEAR: o_RstCounter=1, o_ActCounter=0, o_Busy=1.
  - i_RstOK=1 AND i_Count==0: go to RUN. Both are required because i_RstOK alone may be stale high.
  - Otherwise tmo<=tmo+1; when tmo==RST_TIMEOUT-1, go to ERROR.
  - With a live counter, CLEAR lasts 2 cycles (counter clears one edge after seeing o_RstCounter).
- RUN: o_ActCounter=1, o_RstCounter=0, o_Busy=1.
  - i_TwoSec=1 and remaining==1: remaining<=0, go to DONE.
  - i_TwoSec=1 and remaining>1: remaining<=remaining-1, tmo<=0, go to CLEAR.
  - i_TwoSec=0: stay.
- DONE: o_Done=1 for exactly one cycle, then IDLE unconditionally. i_Start is ignored in DONE.
- ERROR: o_Err=1 held, all other outputs 0. Leave only on i_Abort=1 or reset; go to IDLE, tmo<=0, remaining<=0.
- i_Abort=1 in CLEAR or RUN: go to IDLE next edge, remaining<=0, no o_Done.
  - Abort has priority over a simultaneous i_TwoSec or i_RstOK.
- i_Start while not in IDLE: ignored; not queued.
- o_Remaining reflects the remaining register directly (0 in IDLE/DONE/ERROR).
- o_ActCounter and o_RstCounter are never high in the same cycle.
- Reset has priority over abort, start and all counter inputs, in any state.
- remaining never wraps: decrement only when >1, otherwise set 0.

Test Plan:
1. Reset low 2 cycles, then high -> all outputs 0, o_Remaining=0.
2. Start with i_Periods=1; model counter clears 1 cycle after o_RstCounter; i_TwoSec after 4095 counts -> o_RstCounter high 2 cycles, o_ActCounter high until i_TwoSec, o_Done pulses exactly once, then idle.
3. i_Periods=3 -> 3 CLEAR/RUN pairs, o_Remaining steps 3,2,1,0, exactly one o_Done after third i_TwoSec.
4. i_RstOK stuck high but i_Count stays 57 -> o_Err rises after RST_TIMEOUT=8 cycles in CLEAR; i_Abort=1 -> IDLE, o_Err=0.
5. i_Abort and i_TwoSec same cycle in RUN with remaining=1 -> IDLE, no o_Done; then i_Start while in DONE of a later request -> ignored.
6. i_Periods=0 with i_Start -> o_Done one cycle later, o_RstCounter and o_ActCounter never asserted; reset mid-RUN -> IDLE immediately.
